// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit for the multi-cycle ysyx_22050710 core: REQ -> WAIT -> ISSUE -> EXEC loop.
// Optional misaligned-target trap enabled by defining YSYX_22050710_IFU_ALIGN_CHK_EN.
module ysyx_22050710_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_imem_rsp_ready,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [63:0] o_pc,
  input  logic        i_dnpc_valid,
  input  logic [63:0] i_dnpc,
  output logic        o_dnpc_ready,
  output logic        o_fetch_err
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [ILEN-1:0]   inst_q, inst_d;

`ifdef YSYX_22050710_IFU_ALIGN_CHK_EN
  logic err_q, err_d;
`endif

  // State, PC and instruction registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= ILEN'(0);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef YSYX_22050710_IFU_ALIGN_CHK_EN
  // Sticky misaligned-target flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // Next-state logic; each handshake is honoured only in its owning state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef YSYX_22050710_IFU_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_REQ: begin
        if (i_imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          inst_d  = i_imem_rsp_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_inst_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (i_dnpc_valid) begin
`ifdef YSYX_22050710_IFU_ALIGN_CHK_EN
          if (i_dnpc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            pc_d    = i_dnpc;
            state_d = S_REQ;
          end
`else
          pc_d    = i_dnpc;
          state_d = S_REQ;
`endif
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Outputs are decoded from registered state only
  assign o_imem_req_valid = (state_q == S_REQ);
  assign o_imem_rsp_ready = (state_q == S_WAIT);
  assign o_inst_valid     = (state_q == S_ISSUE);
  assign o_dnpc_ready     = (state_q == S_EXEC);
  assign o_imem_addr      = pc_q;
  assign o_pc             = pc_q;
  assign o_inst           = inst_q;

`ifdef YSYX_22050710_IFU_ALIGN_CHK_EN
  assign o_fetch_err = err_q;
`else
  assign o_fetch_err = 1'b0;
`endif

endmodule
